// File: rtl/acum_drain.sv
// Drain engine for the accumulator output FIFO: pops 4x32-bit partial-sum rows,
// requantizes each lane to int8 and writes the packed row to memory at base + n*stride.
module acum_drain #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [CNT_W-1:0]        count,
    input  logic [4:0]              shift,
    input  logic                    relu,
    input  logic                    buf_empty,
    output logic                    buf_rd_en,
    input  logic [LANES*LANE_W-1:0] buf_data,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANES*OUT_W-1:0]  mem_wdata,
    output logic                    mem_wvalid,
    input  logic                    mem_wready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_LAT, S_WR, S_DONE} state_t;
    typedef logic signed [LANE_W:0] wide_t;

    localparam wide_t MAX_V = wide_t'((2 ** (OUT_W - 1)) - 1);
    localparam wide_t MIN_V = wide_t'(-(2 ** (OUT_W - 1)));

    state_t                   state, state_nx;
    logic [ADDR_W-1:0]        addr_q, stride_q;
    logic [CNT_W-1:0]         remaining;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic [LANES*OUT_W-1:0]   wdata_q, row_q;

    // Lane width grows by one bit so the rounding add cannot overflow.
    always_comb begin
        wide_t x;
        wide_t rnd;
        row_q = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            x   = wide_t'($signed(buf_data[LANE_W*i +: LANE_W]));
            rnd = '0;
            if (shift_q != 5'd0) begin
                rnd = wide_t'(1) <<< (shift_q - 5'd1);
                x   = (x + rnd) >>> shift_q;
            end
            if (relu_q && x < 0)
                x = '0;
            if (x > MAX_V)
                x = MAX_V;
            else if (x < MIN_V)
                x = MIN_V;
            row_q[OUT_W*i +: OUT_W] = x[OUT_W-1:0];
        end
    end

    always_comb begin
        state_nx  = state;
        buf_rd_en = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = (count == '0) ? S_DONE : S_REQ;
            S_REQ: begin
                if (!buf_empty) begin
                    buf_rd_en = 1'b1;
                    state_nx  = S_LAT;
                end
            end
            S_LAT:  state_nx = S_WR;
            S_WR: begin
                if (mem_wready)
                    state_nx = (remaining == CNT_W'(1)) ? S_DONE : S_REQ;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            stride_q  <= '0;
            remaining <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        stride_q  <= stride;
                        remaining <= count;
                        shift_q   <= shift;
                        relu_q    <= relu;
                    end
                end
                S_LAT: wdata_q <= row_q;
                S_WR: begin
                    if (mem_wready) begin
                        addr_q    <= addr_q + stride_q;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wvalid = (state == S_WR);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_acum_drain.sv
// Scoreboard bench for acum_drain: a FIFO model feeds rows, a monitor checks
// each memory write against hand-computed expectations queued by the stimulus.
module tb_acum_drain;

    logic         clk, rst, start, relu, buf_empty, buf_rd_en;
    logic [31:0]  base_addr, stride, mem_addr, mem_wdata;
    logic [15:0]  count;
    logic [4:0]   shift;
    logic [127:0] buf_data;
    logic         mem_wvalid, mem_wready, busy, done;

    acum_drain #(.LANES(4), .LANE_W(32), .OUT_W(8), .ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
        .count(count), .shift(shift), .relu(relu), .buf_empty(buf_empty),
        .buf_rd_en(buf_rd_en), .buf_data(buf_data), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int pops = 0, writes = 0, done_cnt = 0;
    int fifo_n = 0, stall_left = 0;
    bit force_empty = 0, rand_stall = 0, hold_low = 0;
    logic [127:0] fifo_q[$];
    logic [31:0]  exp_addr[$], exp_data[$];

    assign buf_empty = force_empty || (fifo_n == 0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] row(input int l0, input int l1, input int l2, input int l3);
        return {l3[31:0], l2[31:0], l1[31:0], l0[31:0]};
    endfunction

    task automatic push_row(input logic [127:0] r);
        fifo_q.push_back(r);
        fifo_n = fifo_q.size();
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // FIFO model: data appears the cycle after the pop request.
    initial begin
        bit pop_req;
        buf_data = '0;
        forever begin
            @(negedge clk);
            pop_req = buf_rd_en;
            if (buf_rd_en) check("pop_when_empty", {63'd0, buf_empty}, 64'd0);
            @(posedge clk);
            #1;
            if (pop_req && fifo_q.size() > 0) begin
                buf_data = fifo_q.pop_front();
                pops++;
            end
            fifo_n = fifo_q.size();
        end
    end

    initial begin
        mem_wready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) mem_wready = 1'b0;
            else if (mem_wvalid) begin
                if (stall_left > 0) begin
                    mem_wready = 1'b0;
                    stall_left--;
                end else mem_wready = 1'b1;
            end else begin
                mem_wready = 1'b0;
                stall_left = rand_stall ? int'($urandom_range(4, 0)) : 0;
            end
        end
    end

    // Monitor: every cycle with wvalid must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_wvalid) begin
            if (exp_addr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
            end else begin
                check("wr_addr", {32'd0, mem_addr}, {32'd0, exp_addr[0]});
                check("wr_data", {32'd0, mem_wdata}, {32'd0, exp_data[0]});
                if (mem_wready) begin
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                    writes++;
                end
            end
        end
    end

    task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c,
                             input logic [4:0] sh, input logic r);
        @(posedge clk); #1;
        base_addr = b; stride = s; count = c; shift = sh; relu = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = '1; stride = '1; count = 16'd7; shift = 5'd9; relu = ~r;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_busy_low"}, {63'd0, busy}, 64'd0);
        check({name, "_sb_empty"}, 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        int p0, w0, d0, t;
        rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; count = '0; shift = '0; relu = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {mem_addr, mem_wdata}, 64'd0);
        check("rst_flags", {60'd0, buf_rd_en, mem_wvalid, busy, done}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: saturation at shift 0
        push_row(row(100, -5, 300, -300));
        expect_wr(32'h100, 32'h807FFB64);
        p0 = pops;
        start_job(32'h100, 32'h10, 16'd1, 5'd0, 1'b0);
        @(negedge clk);
        check("t1_busy", {63'd0, busy}, 64'd1);
        wait_done("t1");
        check("t1_pops", 64'(pops - p0), 64'd1);

        // 2: rounding shift, with and without ReLU; 31-bit shift needs the extra bit
        push_row(row(6, 5, -6, -7));
        expect_wr(32'h200, 32'hFEFF0102);
        start_job(32'h200, 32'h4, 16'd1, 5'd2, 1'b0);
        wait_done("t2a");
        push_row(row(6, 5, -6, -7));
        expect_wr(32'h300, 32'h00000102);
        start_job(32'h300, 32'h4, 16'd1, 5'd2, 1'b1);
        wait_done("t2b");
        push_row(row(32'h7FFFFFFF, 32'h80000000, 32'h40000000, 32'h3FFFFFFF));
        expect_wr(32'h400, 32'h0001FF01);
        start_job(32'h400, 32'h4, 16'd1, 5'd31, 1'b0);
        wait_done("t2c");

        // 3: multi-row with stalls; a start while busy is ignored
        rand_stall = 1;
        push_row(row(1, 2, 3, 4));
        push_row(row(-1, -2, 127, 128));
        push_row(row(0, -128, -129, 1000));
        expect_wr(32'h1000, 32'h04030201);
        expect_wr(32'h1040, 32'h7F7FFEFF);
        expect_wr(32'h1080, 32'h7F808000);
        p0 = pops; w0 = writes;
        start_job(32'h1000, 32'h40, 16'd3, 5'd0, 1'b0);
        repeat (4) @(posedge clk);
        start_job(32'hDEAD0000, 32'h8, 16'd5, 5'd1, 1'b1);
        wait_done("t3");
        check("t3_pops", 64'(pops - p0), 64'd3);
        check("t3_writes", 64'(writes - w0), 64'd3);
        rand_stall = 0;

        // 4: FIFO empty in REQ
        force_empty = 1;
        push_row(row(-1, 0, 1, 2));
        expect_wr(32'h2000, 32'h0201_00FF);
        p0 = pops;
        start_job(32'h2000, 32'h4, 16'd1, 5'd0, 1'b0);
        repeat (10) @(negedge clk);
        check("t4_no_pop", 64'(pops - p0), 64'd0);
        check("t4_wait_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1 force_empty = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!buf_rd_en && t < 20);
        check("t4_pop_seen", {63'd0, buf_rd_en}, 64'd1);
        @(negedge clk);
        check("t4_lat_flags", {62'd0, buf_rd_en, mem_wvalid}, 64'd0);
        @(negedge clk);
        check("t4_wvalid_2cyc", {63'd0, mem_wvalid}, 64'd1);
        wait_done("t4");
        check("t4_pops", 64'(pops - p0), 64'd1);

        // 5: empty job
        p0 = pops; w0 = writes;
        start_job(32'h3000, 32'h4, 16'd0, 5'd0, 1'b0);
        wait_done("t5");
        check("t5_no_pop", 64'(pops - p0), 64'd0);
        check("t5_no_write", 64'(writes - w0), 64'd0);

        // 6: reset while a write is pending
        hold_low = 1;
        push_row(row(10, 20, 30, 40));
        push_row(row(50, 60, 70, 80));
        expect_wr(32'h4000, 32'h281E140A);
        d0 = done_cnt;
        start_job(32'h4000, 32'h8, 16'd2, 5'd0, 1'b0);
        t = 0;
        do begin @(negedge clk); t++; end while (!mem_wvalid && t < 20);
        check("t6_in_wr", {63'd0, mem_wvalid}, 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_addr.delete(); exp_data.delete(); fifo_q.delete(); fifo_n = 0;
        hold_low = 0;
        @(negedge clk);
        check("t6_rst_flags", {61'd0, mem_wvalid, busy, done}, 64'd0);
        check("t6_rst_regs", {mem_addr, mem_wdata}, 64'd0);
        repeat (3) @(negedge clk);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        push_row(row(-3, 3, 255, -255));
        push_row(row(16, -16, 0, 7));
        expect_wr(32'h5000, 32'h807F03FD);
        expect_wr(32'h4FF8, 32'h07_00_F0_10);
        start_job(32'h5000, 32'hFFFFFFF8, 16'd2, 5'd0, 1'b0);
        wait_done("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
